rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and load scoreboard for the 16-entry processor register file. Two writeback sources compete for the single register-file write port: the ALU result path and the data-memory load-return path. The block grants one per cycle, drives the registered write enable, address and data into the register file, and tracks registers with outstanding loads. From that tracking it produces a read-hazard stall for the decode stage.

## Interface
- DATA_W, 32, register width (matches register-file entry width)
- NREG, 16, number of registers; address width is log2(NREG) = 4
- STARVE_MAX, 3, consecutive ALU denials before the ALU is force-granted

- CLOCK_50  in  1  system clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  4  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- mem_valid  in  1  load-return writeback request
- mem_rd  in  4  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle (combinational)
- load_issue  in  1  a load has been issued to memory this cycle
- load_rd  in  4  destination register of the issued load
- chk_en  in  3  enables for the {m, s, n} hazard checks
- chk_n, chk_s, chk_m  in  4 each  source registers read by the instruction in decode
- stall  out  1  decode must hold (combinational)
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  4  register-file write address (registered)
- wr_data  out  DATA_W  register-file write data (registered)
- grant_src  out  1  source of the last write: 0 = ALU, 1 = MEM (registered)
- busy  out  NREG  scoreboard: bit i = load pending on Ri
- sb_err  out  1  sticky scoreboard protocol error

## Operation
- Eligibility:
  - alu_elig = alu_valid & !busy[alu_rd]. This is the WAW guard: an ALU write never overtakes an older load to the same register.
  - mem_elig = mem_valid.
- Arbitration:
  - MEM has fixed priority.
  - Exception: when the starve counter equals STARVE_MAX and alu_elig = 1, the ALU is granted and mem_ready = 0.
  - At most one of alu_ready and mem_ready is high in any cycle.
- Starve counter (2 bits):
  - Increments when alu_elig & !alu_ready, saturating at STARVE_MAX.
  - Clears on an ALU grant, or when alu_elig = 0.
- Scoreboard update:
  - An accepted MEM write clears busy[mem_rd].
  - load_issue sets busy[load_rd].
  - If the set and the clear target the same register in the same cycle, the set wins and the bit stays 1.
- Protocol errors (sb_err set, sticky until reset):
  - load_issue to a register whose busy bit is already 1. The scoreboard bit is unchanged.
  - An accepted MEM write to a register whose busy bit is 0. The write still proceeds.
- Stall: for each enabled check x in {n, s, m}, stall = 1 if either condition holds:
  - busy[chk_x] = 1
  - wr_en = 1 and wr_addr = chk_x (write in flight, not yet visible in the register file)
- R15 (PC mirror) gets no special treatment; writes to address 15 arbitrate like any other.

## Timing
- Reset values:
  - wr_en = 0, wr_addr = 0, wr_data = 0, grant_src = 0
  - busy = 0, starve counter = 0, sb_err = 0
- Handshake: a transfer happens at the rising edge where valid & ready = 1. The requester holds rd and data stable until it is accepted.
- Write latency: the grant in cycle N appears on wr_en/wr_addr/wr_data in cycle N+1. wr_en is a single-cycle pulse per grant.
- Back-to-back grants produce wr_en high on consecutive cycles.
- A busy bit changes one cycle after the accepting or issuing edge. stall reflects the updated bit in that same next cycle.
- alu_ready, mem_ready and stall are combinational from inputs and registered state; none has a combinational path to its own inputs.
- Reset asserted mid-operation clears all state immediately, including pending busy bits. In-flight requests are dropped, and requesters must re-present them after reset.

## Test plan
- Reset: hold RESET_N = 0 with all valids high -> wr_en = 0, busy = 0, both readys = 0 stay low through reset; the first grant comes only after release.
- Priority and latency: alu_valid = 1 (rd = 3, data = 0x11) and mem_valid = 1 (rd = 5, data = 0x22) in cycle N, with busy[5] set beforehand -> mem_ready = 1 in N; cycle N+1 shows wr_en = 1, wr_addr = 5, wr_data = 0x22, grant_src = 1, busy[5] = 0.
- Starvation: mem_valid and alu_valid held high for 5 cycles -> MEM is granted in cycles 0-2, the ALU is force-granted in cycle 3 with mem_ready = 0, and MEM is granted again in cycle 4.
- Scoreboard stall: load_issue with load_rd = 7, then chk_en = 3'b001 with chk_n = 7 -> stall = 1 until the MEM write to R7 is accepted, stays 1 for the in-flight wr_en cycle, then 0.
- WAW guard: busy[2] = 1 and alu_valid with alu_rd = 2 -> alu_ready = 0 until the MEM write to R2 is accepted; the ALU write is issued on a later cycle.
- Errors and collisions:
  - load_issue to an already-busy R4 -> sb_err = 1 and stays 1.
  - Same-cycle MEM clear and load_issue on R9 -> busy[9] = 1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter
//  Purpose  : Write-port arbiter and load scoreboard for the 16-entry
//             register file. It picks one of the two writeback sources
//             (ALU result, memory load return) each cycle and drives a
//             registered write into the register file. It also tracks
//             registers with outstanding loads and raises a decode stall
//             on read hazards.
//  Ports    :
//    CLOCK_50, RESET_N             clock, asynchronous active-low reset
//    alu_valid/alu_rd/alu_data     ALU writeback request
//    alu_ready                     ALU request accepted (combinational)
//    mem_valid/mem_rd/mem_data     load-return writeback request
//    mem_ready                     load request accepted (combinational)
//    load_issue/load_rd            load issued to memory this cycle
//    chk_en, chk_n, chk_s, chk_m   decode source-register hazard checks
//    stall                         decode must hold (combinational)
//    wr_en/wr_addr/wr_data         register-file write port (registered)
//    grant_src                     source of last write, 0 = ALU, 1 = MEM
//    busy                          per-register pending-load bits
//    sb_err                        sticky scoreboard protocol error
//  Revision : 1.0  initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int NREG       = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    alu_valid,
    input  logic [$clog2(NREG)-1:0] alu_rd,
    input  logic [DATA_W-1:0]       alu_data,
    output logic                    alu_ready,
    input  logic                    mem_valid,
    input  logic [$clog2(NREG)-1:0] mem_rd,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    mem_ready,
    input  logic                    load_issue,
    input  logic [$clog2(NREG)-1:0] load_rd,
    input  logic [2:0]              chk_en,
    input  logic [$clog2(NREG)-1:0] chk_n,
    input  logic [$clog2(NREG)-1:0] chk_s,
    input  logic [$clog2(NREG)-1:0] chk_m,
    output logic                    stall,
    output logic                    wr_en,
    output logic [$clog2(NREG)-1:0] wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    grant_src,
    output logic [NREG-1:0]         busy,
    output logic                    sb_err
);

    localparam int AW       = $clog2(NREG);
    localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_MAX);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                r_wr_en;
    logic [AW-1:0]       r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_grant_src;
    logic [NREG-1:0]     r_busy;
    logic [STARVE_W-1:0] r_starve;
    logic                r_sb_err;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic w_alu_elig;
    logic w_force_alu;
    logic w_alu_fire;
    logic w_mem_fire;

    // An ALU write must never overtake an older load to the same register.
    assign w_alu_elig  = alu_valid & ~r_busy[alu_rd];
    assign w_force_alu = w_alu_elig & (r_starve == C_STARVE_MAX);

    // Both readys are held low while in reset so nothing is accepted
    // across the reset boundary.
    assign mem_ready = RESET_N & mem_valid & ~w_force_alu;
    assign alu_ready = RESET_N & w_alu_elig & (w_force_alu | ~mem_valid);

    assign w_alu_fire = alu_ready;   // alu_ready already implies alu_valid
    assign w_mem_fire = mem_ready;   // mem_ready already implies mem_valid

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles an eligible ALU
    // request lost to MEM; cleared by an ALU grant or loss of eligibility.
    // ------------------------------------------------------------------
    logic [STARVE_W-1:0] w_starve_nxt;

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_alu_fire || !w_alu_elig) begin
            w_starve_nxt = '0;
        end else if (r_starve != C_STARVE_MAX) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state. The load-issue set is applied after the MEM
    // clear so a same-cycle collision on one register leaves it busy.
    // ------------------------------------------------------------------
    logic [NREG-1:0] w_busy_nxt;
    logic            w_err_issue;
    logic            w_err_mem;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_mem_fire) begin
            w_busy_nxt[mem_rd] = 1'b0;
        end
        if (load_issue) begin
            w_busy_nxt[load_rd] = 1'b1;
        end
    end

    assign w_err_issue = load_issue & r_busy[load_rd];
    assign w_err_mem   = w_mem_fire & ~r_busy[mem_rd];

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_grant_src <= 1'b0;
            r_busy      <= '0;
            r_starve    <= '0;
            r_sb_err    <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_starve <= w_starve_nxt;
            if (w_err_issue || w_err_mem) begin
                r_sb_err <= 1'b1;
            end

            // Address/data/source hold their last value between writes.
            r_wr_en <= w_mem_fire | w_alu_fire;
            if (w_mem_fire) begin
                r_wr_addr   <= mem_rd;
                r_wr_data   <= mem_data;
                r_grant_src <= 1'b1;
            end else if (w_alu_fire) begin
                r_wr_addr   <= alu_rd;
                r_wr_data   <= alu_data;
                r_grant_src <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode hazard stall. A register is hazardous while its load is
    // pending or while its write sits in the output register and is not
    // yet visible in the register file.
    // ------------------------------------------------------------------
    logic [AW-1:0] w_chk_reg [3];
    logic [2:0]    w_hit;

    assign w_chk_reg[0] = chk_n;
    assign w_chk_reg[1] = chk_s;
    assign w_chk_reg[2] = chk_m;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 3; i++) begin
            w_hit[i] = chk_en[i] &
                       (r_busy[w_chk_reg[i]] | (r_wr_en & (r_wr_addr == w_chk_reg[i])));
        end
    end

    assign stall = |w_hit;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign grant_src = r_grant_src;
    assign busy      = r_busy;
    assign sb_err    = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_wb_arbiter
//  Purpose  : Directed self-checking bench for rf_wb_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int NREG   = 16;

    logic              CLOCK_50;
    logic              RESET_N;
    logic              alu_valid;
    logic [3:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [3:0]        mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              load_issue;
    logic [3:0]        load_rd;
    logic [2:0]        chk_en;
    logic [3:0]        chk_n;
    logic [3:0]        chk_s;
    logic [3:0]        chk_m;
    logic              stall;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              grant_src;
    logic [NREG-1:0]   busy;
    logic              sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_arbiter #(
        .DATA_W    (DATA_W),
        .NREG      (NREG),
        .STARVE_MAX(3)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .load_issue(load_issue),
        .load_rd   (load_rd),
        .chk_en    (chk_en),
        .chk_n     (chk_n),
        .chk_s     (chk_s),
        .chk_m     (chk_m),
        .stall     (stall),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_src (grant_src),
        .busy      (busy),
        .sb_err    (sb_err)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 ns after the edge.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle();
        alu_valid  = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid  = 1'b0; mem_rd = '0; mem_data = '0;
        load_issue = 1'b0; load_rd = '0;
        chk_en     = '0; chk_n = '0; chk_s = '0; chk_m = '0;
    endtask

    task automatic do_reset();
        idle();
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    logic [4:0] exp_mem_rdy;
    logic [4:0] exp_alu_rdy;

    initial begin
        idle();
        RESET_N = 1'b0;

        // ---------------- Reset with all requests active ----------------
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 32'h1;
        mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 32'h2;
        load_issue = 1'b1; load_rd = 4'd3;
        tick();
        tick();
        #2;
        check("rst_wr_en",     wr_en,     0);
        check("rst_wr_addr",   wr_addr,   0);
        check("rst_wr_data",   wr_data,   0);
        check("rst_grant_src", grant_src, 0);
        check("rst_busy",      busy,      0);
        check("rst_sb_err",    sb_err,    0);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        tick();
        check("rst_hold_wr_en", wr_en, 0);
        idle();
        RESET_N = 1'b1;
        tick();
        check("post_rst_wr_en", wr_en, 0);
        check("post_rst_busy",  busy,  0);

        // ---------------- Priority and latency ----------------
        do_reset();
        load_issue = 1'b1; load_rd = 4'd5;
        tick();
        load_issue = 1'b0;
        check("prio_busy5_set", busy, 16'h0020);
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 32'h22;
        #2;
        check("prio_mem_ready", mem_ready, 1);
        check("prio_alu_ready", alu_ready, 0);
        tick();
        mem_valid = 1'b0;
        check("prio_wr_en",     wr_en,     1);
        check("prio_wr_addr",   wr_addr,   5);
        check("prio_wr_data",   wr_data,   32'h22);
        check("prio_grant_src", grant_src, 1);
        check("prio_busy5_clr", busy,      0);
        check("prio_sb_err",    sb_err,    0);
        #2;
        check("prio_alu_ready2", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        check("b2b_wr_en",     wr_en,     1);
        check("b2b_wr_addr",   wr_addr,   3);
        check("b2b_wr_data",   wr_data,   32'h11);
        check("b2b_grant_src", grant_src, 0);
        tick();
        check("pulse_wr_en", wr_en, 0);

        // ---------------- Starvation ----------------
        do_reset();
        exp_mem_rdy = 5'b10111;   // bit k = cycle k
        exp_alu_rdy = 5'b01000;
        alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 32'hA6;
        mem_valid = 1'b1; mem_rd = 4'd8; mem_data = 32'hB8;
        for (int k = 0; k < 5; k++) begin
            #2;
            check($sformatf("starve_mem_ready_c%0d", k), mem_ready, exp_mem_rdy[k]);
            check($sformatf("starve_alu_ready_c%0d", k), alu_ready, exp_alu_rdy[k]);
            tick();
            if (k == 3) begin
                check("starve_force_src",  grant_src, 0);
                check("starve_force_addr", wr_addr,   6);
            end
        end
        idle();
        tick();

        // ---------------- Scoreboard stall ----------------
        do_reset();
        load_issue = 1'b1; load_rd = 4'd7;
        tick();
        load_issue = 1'b0;
        chk_n = 4'd7;
        #2;
        check("stall_disabled", stall, 0);
        chk_en = 3'b001;
        #2;
        check("stall_busy_n", stall, 1);
        chk_en = 3'b100; chk_m = 4'd7; chk_n = 4'd0;
        #2;
        check("stall_busy_m", stall, 1);
        chk_en = 3'b001; chk_n = 4'd7; chk_m = 4'd0;
        tick();
        check("stall_hold", stall, 1);
        mem_valid = 1'b1; mem_rd = 4'd7; mem_data = 32'h77;
        #2;
        check("stall_accept_cycle", stall, 1);
        tick();
        mem_valid = 1'b0;
        check("stall_inflight_busy", busy[7], 0);
        check("stall_inflight", stall, 1);
        tick();
        check("stall_clear", stall, 0);
        idle();

        // ---------------- WAW guard ----------------
        do_reset();
        load_issue = 1'b1; load_rd = 4'd2;
        tick();
        load_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd2; alu_data = 32'h55;
        #2;
        check("waw_blocked0", alu_ready, 0);
        tick();
        check("waw_blocked1", alu_ready, 0);
        check("waw_no_write", wr_en, 0);
        mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 32'h66;
        #2;
        check("waw_mem_ready", mem_ready, 1);
        check("waw_blocked2",  alu_ready, 0);
        tick();
        mem_valid = 1'b0;
        check("waw_mem_wr_data", wr_data, 32'h66);
        #2;
        check("waw_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        check("waw_alu_wr_addr", wr_addr,   2);
        check("waw_alu_wr_data", wr_data,   32'h55);
        check("waw_alu_src",     grant_src, 0);

        // ---------------- Collision on R9 ----------------
        do_reset();
        load_issue = 1'b1; load_rd = 4'd9;
        tick();
        mem_valid = 1'b1; mem_rd = 4'd9; mem_data = 32'h99;
        tick();
        idle();
        check("coll_busy9",   busy,    16'h0200);
        check("coll_wr_addr", wr_addr, 9);

        // ---------------- Double issue error ----------------
        do_reset();
        check("err_clean", sb_err, 0);
        load_issue = 1'b1; load_rd = 4'd4;
        tick();
        check("err_first_issue", sb_err, 0);
        tick();
        load_issue = 1'b0;
        check("err_double_issue", sb_err, 1);
        check("err_busy4",        busy,   16'h0010);
        tick();
        tick();
        check("err_sticky", sb_err, 1);

        // ---------------- Unmatched MEM write error ----------------
        do_reset();
        mem_valid = 1'b1; mem_rd = 4'd10; mem_data = 32'hAA;
        tick();
        mem_valid = 1'b0;
        check("err_mem_sb",      sb_err,  1);
        check("err_mem_wr_en",   wr_en,   1);
        check("err_mem_wr_addr", wr_addr, 10);

        // ---------------- Asynchronous reset mid-cycle ----------------
        do_reset();
        load_issue = 1'b1; load_rd = 4'd12;
        tick();
        load_issue = 1'b0;
        check("async_pre_busy", busy, 16'h1000);
        #4;
        RESET_N = 1'b0;
        #1;
        check("async_busy_clr", busy,  0);
        check("async_wr_en",    wr_en, 0);
        #3;
        RESET_N = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
